// File: rtl/vga_timing_gen_param_if.sv
// Pixel-side bundle of the VGA timing generator: controls in, sync/colour/coordinates out.
// Latency: n/a (wires only).
// Backpressure: none; the generator is free-running on the pixel clock.
interface vga_timing_gen_param_if #(
    parameter int CW = 10
) ();
    logic          EN;
    logic [1:0]    MODE;
    logic [11:0]   COLOR;
    logic          VGA_HS;
    logic          VGA_VS;
    logic [3:0]    VGA_R;
    logic [3:0]    VGA_G;
    logic [3:0]    VGA_B;
    logic          DE;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          FRAME_START;
    logic [7:0]    FRAME_CNT;

    modport master (
        output EN, MODE, COLOR,
        input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, DE, X, Y, FRAME_START, FRAME_CNT
    );

    modport slave (
        input  EN, MODE, COLOR,
        output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, DE, X, Y, FRAME_START, FRAME_CNT
    );
endinterface

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA raster timing generator with solid/bars/checker/box test patterns.
// Latency: every output registered from the current (h,v) position, exactly 1 cycle, all aligned.
// Backpressure: none; free-running while EN=1, parked at (0,0) with reset-valued outputs while EN=0.
module vga_timing_gen_param #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic                      VGA_CLK,
    input  logic                      RST_N,
    vga_timing_gen_param_if.slave     bus
);
    localparam logic [CW-1:0] H_LAST = CW'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
    localparam logic [CW-1:0] HA_BEG = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] HA_END = CW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CW-1:0] VA_BEG = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] VA_END = CW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [CW-1:0] EDGE   = CW'(8);
    localparam logic [CW-1:0] X_EDGE = CW'(H_ACTIVE - 8);
    localparam logic [CW-1:0] Y_EDGE = CW'(V_ACTIVE - 8);

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [1:0]    mode_q;
    logic          h_last;
    logic          v_last;
    logic          origin;

    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);
    assign origin = (h == '0) && (v == '0);

    // Raster position and the frame-boundary mode latch.
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h      <= '0;
            v      <= '0;
            mode_q <= 2'd0;
        end else if (!bus.EN) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
            // New pattern only takes effect on a frame boundary so a frame is never mixed.
            if (v_last) begin
                mode_q <= bus.MODE;
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    logic          de_c;
    logic [CW-1:0] x_c;
    logic [CW-1:0] y_c;
    logic [2:0]    bar;
    logic          border;
    logic [11:0]   rgb_c;

    // Active-area decode and pixel coordinates of the current position.
    always_comb begin
        de_c = (h >= HA_BEG) && (h < HA_END) && (v >= VA_BEG) && (v < VA_END);
        x_c  = de_c ? h - HA_BEG : '0;
        y_c  = de_c ? v - VA_BEG : '0;
    end

    // Bar index by comparing X against the seven fixed bar boundaries.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_c >= CW'(k * (H_ACTIVE / 8))) begin
                bar = 3'(k);
            end
        end
    end

    // Pattern selection; blanking always forces black.
    always_comb begin
        border = (x_c < EDGE) || (x_c >= X_EDGE) || (y_c < EDGE) || (y_c >= Y_EDGE);
        case (mode_q)
            2'd0:    rgb_c = bus.COLOR;
            2'd1:    rgb_c = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            2'd2:    rgb_c = {12{x_c[5] ^ y_c[5]}};
            default: rgb_c = border ? 12'hFFF : bus.COLOR;
        endcase
        if (!de_c) begin
            rgb_c = 12'h000;
        end
    end

    // Output registers; disabling the generator returns every output, frame count included, to reset values.
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.VGA_HS      <= ~HS_POL;
            bus.VGA_VS      <= ~VS_POL;
            bus.DE          <= 1'b0;
            bus.X           <= '0;
            bus.Y           <= '0;
            bus.VGA_R       <= 4'h0;
            bus.VGA_G       <= 4'h0;
            bus.VGA_B       <= 4'h0;
            bus.FRAME_START <= 1'b0;
            bus.FRAME_CNT   <= 8'd0;
        end else if (!bus.EN) begin
            bus.VGA_HS      <= ~HS_POL;
            bus.VGA_VS      <= ~VS_POL;
            bus.DE          <= 1'b0;
            bus.X           <= '0;
            bus.Y           <= '0;
            bus.VGA_R       <= 4'h0;
            bus.VGA_G       <= 4'h0;
            bus.VGA_B       <= 4'h0;
            bus.FRAME_START <= 1'b0;
            bus.FRAME_CNT   <= 8'd0;
        end else begin
            bus.VGA_HS      <= (h < HS_END) ? HS_POL : ~HS_POL;
            bus.VGA_VS      <= (v < VS_END) ? VS_POL : ~VS_POL;
            bus.DE          <= de_c;
            bus.X           <= x_c;
            bus.Y           <= y_c;
            bus.VGA_R       <= rgb_c[11:8];
            bus.VGA_G       <= rgb_c[7:4];
            bus.VGA_B       <= rgb_c[3:0];
            bus.FRAME_START <= origin;
            if (origin) begin
                bus.FRAME_CNT <= bus.FRAME_CNT + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Randomised bench for vga_timing_gen_param on a shrunken raster, checked against a frame-position model.
// Latency: model predicts each registered output one clock after the position it was computed from.
// Backpressure: none; stimulus is EN/MODE/COLOR/reset changes applied on the falling edge.
module tb_vga_timing_gen_param;
    localparam int  HS = 8,  HB = 8,  HA = 64, HF = 8;
    localparam int  VS = 2,  VB = 3,  VA = 40, VF = 2;
    localparam int  CW = 8;
    localparam bit  HP = 1'b0;
    localparam bit  VP = 1'b1;
    localparam int  HT = HS + HB + HA + HF;
    localparam int  VT = VS + VB + VA + VF;
    localparam int  FR = HT * VT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_param_if #(.CW(CW)) bus ();

    vga_timing_gen_param #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(HP), .VS_POL(VP), .CW(CW)
    ) dut (
        .VGA_CLK (clk),
        .RST_N   (rst_n),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: position within the frame, latched pattern, frame count.
    int t      = 0;
    int mode_l = 0;
    int fcnt   = 0;
    int last_mode = 0;
    int cyc    = 0;
    int fs_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] obs();
        return {24'd0, bus.VGA_HS, bus.VGA_VS, bus.DE, bus.VGA_R, bus.VGA_G, bus.VGA_B,
                bus.X, bus.Y, bus.FRAME_START, bus.FRAME_CNT};
    endfunction

    function automatic logic [63:0] rst_pack();
        return {24'd0, ~HP, ~VP, 1'b0, 12'h000, 8'd0, 8'd0, 1'b0, 8'd0};
    endfunction

    // Reference: outputs expected for frame position p under pattern m.
    function automatic logic [63:0] ref_out(input int p, input int m, input logic [11:0] color, input int fc);
        int h, v, x, y, b;
        logic hs, vs, de, fs, brd;
        logic [11:0] rgb;
        h  = p % HT;
        v  = p / HT;
        hs = (h < HS) ? HP : ~HP;
        vs = (v < VS) ? VP : ~VP;
        de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        x  = de ? h - (HS + HB) : 0;
        y  = de ? v - (VS + VB) : 0;
        rgb = 12'h000;
        if (de) begin
            case (m)
                0: rgb = color;
                1: begin
                    b = x * 8 / HA;
                    rgb = {((b / 4) % 2 == 1) ? 4'hF : 4'h0,
                           ((b / 2) % 2 == 1) ? 4'hF : 4'h0,
                           (b % 2 == 1)       ? 4'hF : 4'h0};
                end
                2: rgb = (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
                default: begin
                    brd = (x < 8) || (x >= HA - 8) || (y < 8) || (y >= VA - 8);
                    rgb = brd ? 12'hFFF : color;
                end
            endcase
        end
        fs = (p == 0);
        return {24'd0, hs, vs, de, rgb, 8'(x), 8'(y), fs, 8'(fc)};
    endfunction

    // One clock: predict from pre-edge inputs, then compare on the falling edge.
    task automatic cycle();
        logic [63:0] e;
        if (!rst_n) begin
            t = 0; fcnt = 0; mode_l = 0;
            e = rst_pack();
        end else if (!bus.EN) begin
            t = 0; fcnt = 0;
            e = rst_pack();
        end else begin
            if (t == 0) fcnt = (fcnt + 1) % 256;
            e = ref_out(t, mode_l, bus.COLOR, fcnt);
            last_mode = mode_l;
            if (t == FR - 1) mode_l = int'(bus.MODE);
            t = (t + 1) % FR;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("outs", obs(), e);
        if (bus.FRAME_START) fs_q.push_back(cyc);
        if (last_mode == 1 && bus.DE && bus.Y == 8'd0) begin
            case (bus.X)
                8'd0:  check("bar_x0",  64'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 64'h000);
                8'd7:  check("bar_x7",  64'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 64'h000);
                8'd8:  check("bar_x8",  64'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 64'h00F);
                8'd63: check("bar_x63", 64'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 64'hFFF);
                default: ;
            endcase
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs(), rst_pack());
        t = 0; fcnt = 0; mode_l = 0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int de_n, hs_n, vs_n, off;
        bus.EN    = 1'b0;
        bus.MODE  = 2'd0;
        bus.COLOR = 12'h5A3;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // One full frame in mode 0 while MODE=1 waits for the boundary.
        bus.EN   = 1'b1;
        bus.MODE = 2'd1;
        de_n = 0; hs_n = 0; vs_n = 0;
        for (int i = 0; i < FR; i++) begin
            cycle();
            if (bus.DE) de_n++;
            if (bus.VGA_HS == HP) hs_n++;
            if (bus.VGA_VS == VP) vs_n++;
        end
        check("de_count", 64'(de_n), 64'(HA * VA));
        check("hs_count", 64'(hs_n), 64'(HS * VT));
        check("vs_count", 64'(vs_n), 64'(VS * HT));

        // Colour-bar frame.
        bus.MODE = 2'd0;
        repeat (FR) cycle();
        check("fs_seen", 64'(fs_q.size() >= 2), 64'd1);
        if (fs_q.size() >= 2) check("fs_period", 64'(fs_q[1] - fs_q[0]), 64'(FR));

        // Solid frame with a mid-frame switch to checker, which applies next frame.
        bus.COLOR = 12'h9C1;
        repeat (FR / 2) cycle();
        bus.MODE = 2'd2;
        repeat (FR) cycle();

        // Enable dropped mid-line: restart from the frame origin.
        repeat (37) cycle();
        bus.EN = 1'b0;
        repeat (3) cycle();
        bus.EN = 1'b1;
        cycle();
        check("restart_fs", 64'(bus.FRAME_START), 64'd1);
        check("restart_x",  64'({bus.DE, bus.X, bus.Y}), 64'd0);

        // Randomised traffic.
        off = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(7) == 0) bus.COLOR = 12'($urandom);
            if ($urandom_range(499) == 0) bus.MODE = 2'($urandom_range(3));
            if (!bus.EN) begin
                if (off == 0) bus.EN = 1'b1;
                else off--;
            end else if ($urandom_range(2999) == 0) begin
                bus.EN = 1'b0;
                off = $urandom_range(4);
            end
            if ($urandom_range(5999) == 0) async_reset();
            else cycle();
        end

        // Reset mid-frame after several frames; count restarts at 1.
        bus.EN = 1'b1;
        repeat (2 * FR + 123) cycle();
        check("fcnt_pre_rst", 64'(bus.FRAME_CNT), 64'(fcnt));
        async_reset();
        cycle();
        check("fcnt_first", 64'(bus.FRAME_CNT), 64'd1);
        repeat (FR - 1) cycle();
        check("fcnt_end_frame1", 64'(bus.FRAME_CNT), 64'd1);
        cycle();
        check("fcnt_frame2", 64'(bus.FRAME_CNT), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
